// File: rtl/color_seq_pkg.sv
// Shared types, the power-on palette and the blend arithmetic width rule
// for the colour fade sequencer.
package color_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      FADE
   } state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam int DEFAULT_DEPTH = 8;

   // Entry 0 sits in the most significant slot of the concatenation.
   localparam rgb_t [0:DEFAULT_DEPTH-1] DEFAULT_PALETTE = {
      24'hFF_00_00,   // red
      24'hFF_3C_00,   // orange
      24'hFF_FF_00,   // yellow
      24'h00_FF_00,   // green
      24'h00_00_FF,   // blue
      24'h08_2E_54,   // indigo
      24'hA0_20_F0,   // purple
      24'hFF_FF_FF    // white
   };

   // One channel of a default entry, zero-extended; entries past the table are black.
   function automatic logic [31:0] default_chan(input int idx, input int ch);
      rgb_t        c;
      logic [31:0] v;
      v = '0;
      if (idx >= 0 && idx < DEFAULT_DEPTH) begin
         c = DEFAULT_PALETTE[idx[2:0]];
         case (ch)
            0:       v = 32'(c.r);
            1:       v = 32'(c.g);
            default: v = 32'(c.b);
         endcase
      end
      return v;
   endfunction

   // cur*(N-k) + nxt*k never exceeds (2^duty_w - 1) * 2^k_w.
   function automatic int blend_width(input int duty_w, input int k_w);
      return duty_w + k_w;
   endfunction

endpackage

// File: rtl/color_fade_sequencer_if.sv
// Control, palette-write and duty-output bundle between board logic and the sequencer.
interface color_fade_sequencer_if #(
   parameter int DUTY_W   = 8,
   parameter int N_COLORS = 8
);
   localparam int IDX_W = $clog2(N_COLORS);

   logic                  enable;
   logic                  pause;
   logic                  advance;
   logic                  fade_en;
   logic                  wr_en;
   logic [IDX_W-1:0]      wr_addr;
   logic [3*DUTY_W-1:0]   wr_data;
   logic [DUTY_W-1:0]     r_duty;
   logic [DUTY_W-1:0]     g_duty;
   logic [DUTY_W-1:0]     b_duty;
   logic [IDX_W-1:0]      color_idx;
   logic                  color_change;

   modport master (
      output enable, pause, advance, fade_en, wr_en, wr_addr, wr_data,
      input  r_duty, g_duty, b_duty, color_idx, color_change
   );

   modport slave (
      input  enable, pause, advance, fade_en, wr_en, wr_addr, wr_data,
      output r_duty, g_duty, b_duty, color_idx, color_change
   );
endinterface

// File: rtl/color_blend.sv
// Combinational single-channel linear blend: (cur*(FADE_STEPS-k) + nxt*k) >> K_W.
module color_blend
   import color_seq_pkg::*;
#(
   parameter int DUTY_W     = 8,
   parameter int FADE_STEPS = 16,
   parameter int K_W        = $clog2(FADE_STEPS)
) (
   input  logic [DUTY_W-1:0] cur,
   input  logic [DUTY_W-1:0] nxt,
   input  logic [K_W-1:0]    k,
   output logic [DUTY_W-1:0] duty
);
   localparam int W = blend_width(DUTY_W, K_W);

   logic [W-1:0] cur_w;
   logic [W-1:0] nxt_w;
   logic [W-1:0] wt_cur;
   logic [W-1:0] wt_nxt;
   logic [W-1:0] sum;

   assign cur_w  = W'(cur);
   assign nxt_w  = W'(nxt);
   assign wt_nxt = W'(k);
   assign wt_cur = W'(FADE_STEPS) - wt_nxt;
   assign sum    = cur_w * wt_cur + nxt_w * wt_nxt;
   assign duty   = sum[W-1:K_W];
endmodule

// File: rtl/color_fade_sequencer.sv
// Palette-driven RGB duty sequencer: dwell on each entry, then hard-step or
// crossfade to the next; supports pause, early advance and runtime palette writes.
module color_fade_sequencer
   import color_seq_pkg::*;
#(
   parameter int DUTY_W       = 8,
   parameter int N_COLORS     = 8,
   parameter int DWELL_CYCLES = 62_500_000,
   parameter int STEP_CYCLES  = 1_000_000,
   parameter int FADE_STEPS   = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   color_fade_sequencer_if.slave bus
);
   localparam int IDX_W   = $clog2(N_COLORS);
   localparam int K_W     = $clog2(FADE_STEPS);
   localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int STEP_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int RGB_W   = 3 * DUTY_W;

   function automatic logic [RGB_W-1:0] default_entry(input int i);
      return {DUTY_W'(default_chan(i, 0)), DUTY_W'(default_chan(i, 1)),
              DUTY_W'(default_chan(i, 2))};
   endfunction

   logic [RGB_W-1:0]   palette_reg [N_COLORS];
   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg, idx_next, idx_succ;
   logic [DWELL_W-1:0] dwell_cnt_reg, dwell_next;
   logic [STEP_W-1:0]  step_cnt_reg, step_next;
   logic [K_W-1:0]     k_reg, k_next;
   logic               new_color_reg, new_color_next;
   logic [RGB_W-1:0]   duty_reg, duty_sel;
   logic [IDX_W-1:0]   color_idx_reg;
   logic               color_change_reg;
   logic [RGB_W-1:0]   cur_rgb, nxt_rgb, blend_rgb;
   logic               dwell_done, step_done, k_last;

   assign idx_succ   = (idx_reg == IDX_W'(N_COLORS - 1)) ? '0 : idx_reg + IDX_W'(1);
   assign cur_rgb    = palette_reg[idx_reg];
   assign nxt_rgb    = palette_reg[idx_succ];
   assign dwell_done = (dwell_cnt_reg == DWELL_W'(DWELL_CYCLES - 1));
   assign step_done  = (step_cnt_reg == STEP_W'(STEP_CYCLES - 1));
   assign k_last     = (k_reg == K_W'(FADE_STEPS - 1));

   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      color_blend #(
         .DUTY_W     (DUTY_W),
         .FADE_STEPS (FADE_STEPS),
         .K_W        (K_W)
      ) u_blend (
         .cur  (cur_rgb[(2 - gi) * DUTY_W +: DUTY_W]),
         .nxt  (nxt_rgb[(2 - gi) * DUTY_W +: DUTY_W]),
         .k    (k_reg),
         .duty (blend_rgb[(2 - gi) * DUTY_W +: DUTY_W])
      );
   end

   // Writes land on the clock edge, so a same-cycle read still sees the old entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_COLORS; i++) begin
            palette_reg[i] <= default_entry(i);
         end
      end else if (bus.wr_en) begin
         palette_reg[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      dwell_next     = dwell_cnt_reg;
      step_next      = step_cnt_reg;
      k_next         = k_reg;
      new_color_next = 1'b0;
      if (!bus.enable) begin
         state_next = IDLE;
         idx_next   = '0;
         dwell_next = '0;
         step_next  = '0;
         k_next     = '0;
      end else if (bus.pause) begin
         new_color_next = new_color_reg;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next     = HOLD;
               idx_next       = '0;
               dwell_next     = '0;
               new_color_next = 1'b1;
            end
            HOLD: begin
               if (dwell_done || bus.advance) begin
                  dwell_next = '0;
                  if (bus.fade_en) begin
                     state_next = FADE;
                     k_next     = K_W'(1);
                     step_next  = '0;
                  end else begin
                     idx_next       = idx_succ;
                     new_color_next = 1'b1;
                  end
               end else begin
                  dwell_next = dwell_cnt_reg + DWELL_W'(1);
               end
            end
            FADE: begin
               if (step_done) begin
                  step_next = '0;
                  if (k_last) begin
                     state_next     = HOLD;
                     idx_next       = idx_succ;
                     dwell_next     = '0;
                     new_color_next = 1'b1;
                  end else begin
                     k_next = k_reg + K_W'(1);
                  end
               end else begin
                  step_next = step_cnt_reg + STEP_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      duty_sel = '0;
      case (state_reg)
         HOLD:    duty_sel = cur_rgb;
         FADE:    duty_sel = blend_rgb;
         default: duty_sel = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         dwell_cnt_reg <= '0;
         step_cnt_reg  <= '0;
         k_reg         <= '0;
         new_color_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         dwell_cnt_reg <= dwell_next;
         step_cnt_reg  <= step_next;
         k_reg         <= k_next;
         new_color_reg <= new_color_next;
      end
   end

   // Output stage trails the state by one cycle; color_change rides along so it
   // coincides with the new colour. Paused outputs freeze but the pulse is not stretched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_reg         <= '0;
         color_idx_reg    <= '0;
         color_change_reg <= 1'b0;
      end else if (!bus.enable) begin
         duty_reg         <= '0;
         color_idx_reg    <= '0;
         color_change_reg <= 1'b0;
      end else if (bus.pause) begin
         color_change_reg <= 1'b0;
      end else begin
         duty_reg         <= duty_sel;
         color_idx_reg    <= idx_reg;
         color_change_reg <= new_color_reg;
      end
   end

   assign bus.r_duty       = duty_reg[3*DUTY_W-1 -: DUTY_W];
   assign bus.g_duty       = duty_reg[2*DUTY_W-1 -: DUTY_W];
   assign bus.b_duty       = duty_reg[DUTY_W-1:0];
   assign bus.color_idx    = color_idx_reg;
   assign bus.color_change = color_change_reg;
endmodule

// File: tb/tb_color_fade_sequencer.sv
// Scoreboard bench for color_fade_sequencer: the driver queues the expected output
// for every cycle it drives, and a monitor pops and compares after each rising edge.
module tb_color_fade_sequencer;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   color_fade_sequencer_if #(.DUTY_W(8), .N_COLORS(8)) bus_if ();

   color_fade_sequencer #(
      .DUTY_W       (8),
      .N_COLORS     (8),
      .DWELL_CYCLES (4),
      .STEP_CYCLES  (2),
      .FADE_STEPS   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [2:0] idx;
      logic       cc;
      int         tag;
   } row_t;

   row_t       exp_q [$];
   row_t       mon_row;
   row_t       zero_row;
   int         checks  = 0;
   int         errors  = 0;
   int         cc_seen = 0;
   int         row_no  = 0;
   logic [23:0] pal [8];

   task automatic compare(input row_t e);
      checks++;
      if (bus_if.r_duty !== e.r || bus_if.g_duty !== e.g || bus_if.b_duty !== e.b ||
          bus_if.color_idx !== e.idx || bus_if.color_change !== e.cc) begin
         errors++;
         $display("FAIL test%0d row%0d got rgb=(%0d,%0d,%0d) idx=%0d cc=%0b want rgb=(%0d,%0d,%0d) idx=%0d cc=%0b",
                  e.tag, row_no, bus_if.r_duty, bus_if.g_duty, bus_if.b_duty,
                  bus_if.color_idx, bus_if.color_change, e.r, e.g, e.b, e.idx, e.cc);
      end else begin
         $display("test%0d row%0d rgb=(%0d,%0d,%0d) idx=%0d cc=%0b ok",
                  e.tag, row_no, e.r, e.g, e.b, e.idx, e.cc);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         mon_row = exp_q.pop_front();
         row_no++;
         if (bus_if.color_change === 1'b1) cc_seen++;
         compare(mon_row);
      end
   end

   task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [2:0] idx, input logic cc, input int tag);
      row_t e;
      e.r = r; e.g = g; e.b = b; e.idx = idx; e.cc = cc; e.tag = tag;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic step_pal(input int i, input logic cc, input int tag);
      logic [23:0] c;
      c = pal[i];
      step(c[23:16], c[15:8], c[7:0], 3'(i), cc, tag);
   endtask

   task automatic hold_color(input int i, input int n, input int tag);
      step_pal(i, 1'b1, tag);
      for (int j = 1; j < n; j++) step_pal(i, 1'b0, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      pal[0] = 24'hFF0000; pal[1] = 24'hFF3C00; pal[2] = 24'hFFFF00; pal[3] = 24'h00FF00;
      pal[4] = 24'h0000FF; pal[5] = 24'h082E54; pal[6] = 24'hA020F0; pal[7] = 24'hFFFFFF;
      zero_row.r = '0; zero_row.g = '0; zero_row.b = '0;
      zero_row.idx = '0; zero_row.cc = 1'b0; zero_row.tag = 0;

      bus_if.enable  = 1'b0; bus_if.pause = 1'b0; bus_if.advance = 1'b0;
      bus_if.fade_en = 1'b0; bus_if.wr_en = 1'b0; bus_if.wr_addr = '0;
      bus_if.wr_data = '0;

      // Reset state
      #2 rst_n = 1'b0;
      @(negedge clk);
      compare(zero_row);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 1'b0, 0);
      step(0, 0, 0, 0, 1'b0, 0);

      // 1: hard-step loop through the whole palette and wrap
      bus_if.enable = 1'b1;
      step(0, 0, 0, 0, 1'b0, 1);
      for (int i = 0; i < 8; i++) hold_color(i, 4, 1);
      checks++;
      if (cc_seen != 8) begin
         errors++;
         $display("FAIL cc_count got %0d want 8", cc_seen);
      end else begin
         $display("cc_count %0d ok", cc_seen);
      end
      hold_color(0, 3, 1);

      // 2: crossfade red -> orange
      bus_if.fade_en = 1'b1;
      step_pal(0, 1'b0, 2);
      for (int k = 1; k < 4; k++) begin
         step(8'd255, 8'(15 * k), 8'd0, 3'd0, 1'b0, 2);
         step(8'd255, 8'(15 * k), 8'd0, 3'd0, 1'b0, 2);
      end
      bus_if.fade_en = 1'b0;
      step_pal(1, 1'b1, 2);

      // 3: advance on the 2nd HOLD cycle; advance with pause dropped
      bus_if.advance = 1'b1;
      step_pal(1, 1'b0, 3);
      bus_if.advance = 1'b0;
      step_pal(2, 1'b1, 3);
      bus_if.pause = 1'b1; bus_if.advance = 1'b1;
      step_pal(2, 1'b0, 3);
      bus_if.pause = 1'b0; bus_if.advance = 1'b0;
      step_pal(2, 1'b0, 3);
      step_pal(2, 1'b0, 3);
      bus_if.fade_en = 1'b1;
      step_pal(2, 1'b0, 3);

      // 3/4: yellow -> green fade, advance ignored, 10-cycle pause at k=2
      bus_if.advance = 1'b1;
      step(8'd191, 8'd255, 8'd0, 3'd2, 1'b0, 4);
      bus_if.advance = 1'b0;
      step(8'd191, 8'd255, 8'd0, 3'd2, 1'b0, 4);
      step(8'd127, 8'd255, 8'd0, 3'd2, 1'b0, 4);
      bus_if.pause = 1'b1;
      for (int i = 0; i < 10; i++) step(8'd127, 8'd255, 8'd0, 3'd2, 1'b0, 4);
      bus_if.pause = 1'b0;
      step(8'd127, 8'd255, 8'd0, 3'd2, 1'b0, 4);
      step(8'd63, 8'd255, 8'd0, 3'd2, 1'b0, 4);
      step(8'd63, 8'd255, 8'd0, 3'd2, 1'b0, 4);
      bus_if.fade_en = 1'b0;
      step_pal(3, 1'b1, 4);

      // 6a: enable drop mid-HOLD
      bus_if.enable = 1'b0;
      step(0, 0, 0, 0, 1'b0, 6);
      step(0, 0, 0, 0, 1'b0, 6);
      bus_if.enable = 1'b1; bus_if.fade_en = 1'b1;
      step(0, 0, 0, 0, 1'b0, 6);
      hold_color(0, 4, 6);

      // 5: overwrite the fade target at k=1
      bus_if.wr_en = 1'b1; bus_if.wr_addr = 3'd1; bus_if.wr_data = 24'h000000;
      step(8'd255, 8'd15, 8'd0, 3'd0, 1'b0, 5);
      bus_if.wr_en = 1'b0;
      step(8'd191, 8'd0, 8'd0, 3'd0, 1'b0, 5);
      step(8'd127, 8'd0, 8'd0, 3'd0, 1'b0, 5);
      step(8'd127, 8'd0, 8'd0, 3'd0, 1'b0, 5);
      step(8'd63, 8'd0, 8'd0, 3'd0, 1'b0, 5);

      // 6b: async reset mid-FADE clears outputs at once
      rst_n = 1'b0;
      #1;
      zero_row.tag = 6;
      compare(zero_row);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 7: palette defaults restored after reset
      step(0, 0, 0, 0, 1'b0, 7);
      hold_color(0, 4, 7);
      for (int k = 1; k < 4; k++) begin
         step(8'd255, 8'(15 * k), 8'd0, 3'd0, 1'b0, 7);
         step(8'd255, 8'(15 * k), 8'd0, 3'd0, 1'b0, 7);
      end
      step_pal(1, 1'b1, 7);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/color_fade_sequencer.md
# color_fade_sequencer

Parametrised RGB colour sequencer driving the per-channel PWM generators with duty values. It steps through a runtime-writable palette, either hard-switching or linearly crossfading between consecutive entries. Dwell and fade timing are in clock cycles, and the block supports pause, manual advance and enable control. It sits between the board control logic and the three PWM channel modulators, replacing the fixed-rainbow decoder.

## Interface
- `DUTY_W`, 8, width of each duty value.
- `N_COLORS`, 8, palette depth (≥2); `IDX_W = $clog2(N_COLORS)`.
- `DWELL_CYCLES`, 62_500_000, cycles each colour is held (≥1).
- `STEP_CYCLES`, 1_000_000, cycles per fade step (≥1).
- `FADE_STEPS`, 16, blend steps per transition; power of two, ≥2; `K_W = $clog2(FADE_STEPS)`.
- `clk  in  1  system clock; single clock domain.`
- `rst_n  in  1  asynchronous active-low reset.`
- `enable  in  1  run sequencer; low forces IDLE.`
- `pause  in  1  freeze all counters and outputs.`
- `advance  in  1  one-cycle pulse: end current dwell early.`
- `fade_en  in  1  1 = crossfade transitions, 0 = hard step.`
- `wr_en  in  1  palette write strobe.`
- `wr_addr  in  IDX_W  palette entry to write.`
- `wr_data  in  3*DUTY_W  {R,G,B} value to write.`
- `r_duty, g_duty, b_duty  out  DUTY_W each  registered duty outputs.`
- `color_idx  out  IDX_W  index of current (source) colour.`
- `color_change  out  1  one-cycle pulse on entry to HOLD of a new colour.`

## Operation
- States: IDLE, HOLD, FADE.
- Reset:
  - state IDLE; all outputs 0; `color_idx` 0.
  - Palette loaded from the package default: red (255,0,0), orange (255,60,0), yellow (255,255,0), green (0,255,0), blue (0,0,255), indigo (8,46,84), purple (160,32,240), white (255,255,255). Entries are truncated or zero-filled for other `N_COLORS`/`DUTY_W`.
- IDLE:
  - duties 0.
  - `enable`=1 → HOLD with idx 0, dwell counter 0, `color_change`=1.
- HOLD:
  - duty = palette[idx].
  - The dwell counter ends at `DWELL_CYCLES`-1, or `advance`=1 ends it early.
  - On expiry, if `fade_en`=1 → FADE with k=1; otherwise idx ← next, stay in HOLD, counter reset, `color_change`=1.
- FADE:
  - duty per channel = (cur·(FADE_STEPS−k) + nxt·k) >> K_W, using unsigned arithmetic of width DUTY_W+K_W; the result always fits in DUTY_W.
  - k increments every `STEP_CYCLES`.
  - After k=FADE_STEPS−1 has been held for `STEP_CYCLES` cycles → HOLD with idx ← next, `color_change`=1.
  - `advance` is ignored in FADE.
- next = idx+1; N_COLORS−1 wraps to 0.
- `enable`=0 in any state → IDLE next cycle. idx resets to 0 and duties go to 0.
- `pause`=1 holds the state, all counters, k and outputs. If `pause` and `advance` arrive in the same cycle, pause wins and the advance is dropped (not queued).
- Palette writes take effect the following cycle, including writes to the current or next entry during FADE (the blend uses the new value immediately). Simultaneous write and read of the same entry returns the old value in that cycle.
- `fade_en` is sampled only at dwell expiry; changing it mid-FADE has no effect on the running fade.

## Timing
- Duty outputs are registered from state, idx, k and the palette: one cycle latency after any state or k change.
- HOLD lasts exactly `DWELL_CYCLES` cycles when there is no pause or advance.
- FADE lasts (FADE_STEPS−1)·STEP_CYCLES cycles.
- `color_change` is asserted in the same cycle the new HOLD colour first appears on the duty outputs.
- Async reset assertion clears all outputs immediately. Deassertion is expected synchronous to `clk` (synchroniser upstream).
- Reset mid-FADE returns to IDLE with palette defaults; user writes are lost.

## Structure
- Package `color_seq_pkg` contains:
  - state enum {IDLE, HOLD, FADE};
  - `rgb_t` struct {r,g,b};
  - `DEFAULT_PALETTE` constant;
  - the blend function's width rule.
- Sub-module `color_blend`: combinational single-channel blend (cur, nxt, k → duty), instantiated ×3.
- The palette is a register array inside the top level; no RAM inference is required.

## Test plan
Bench parameters: DWELL_CYCLES=4, STEP_CYCLES=2, FADE_STEPS=4, default palette.
1. Reset, `enable`=1, `fade_en`=0 → (255,0,0) for 4 cycles, then (255,60,0), …; after idx 7 (255,255,255) it wraps to idx 0 (255,0,0); `color_change` pulses 8 times per loop.
2. `fade_en`=1 from red to orange → g_duty sequence 0×4, 15×2, 30×2, 45×2, then 60; r_duty stays 255 throughout.
3. `advance` pulse on the 2nd HOLD cycle → transition starts next cycle. A pulse asserted together with `pause`, or during FADE → no effect.
4. `pause` held 10 cycles mid-FADE at k=2 → duties frozen at the k=2 values; resumes with the remaining step cycles unchanged.
5. Write (0,0,0) to idx 1 while fading 0→1 at k=1 → next output g=0, r=(255·3+0)>>2=191.
6. Deassert `enable` mid-HOLD → duties 0 and idx 0 next cycle. Assert `rst_n`=0 mid-FADE → outputs 0 immediately.
